// File: rtl/m_iter_unit.sv
// m_iter_unit: iterative RV32M-style multiply/divide co-processor on a PCPI
// handshake. Multiply uses a MUL_LAT-deep product pipeline; divide is a
// restoring divider producing one quotient bit per cycle, with optional
// leading-zero skip and single-cycle shortcuts for trivial cases.
//
// Ports:
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   pcpi_valid  in   request present (must stay high until the result)
//   pcpi_insn   in   32-bit instruction word
//   pcpi_rs1    in   XLEN operand 1
//   pcpi_rs2    in   XLEN operand 2
//   pcpi_ready  out  result valid, one-cycle pulse
//   pcpi_wr     out  write-back enable, equal to pcpi_ready
//   pcpi_rd     out  XLEN result, zero when pcpi_ready is low
//   pcpi_busy   out  operation in progress
module m_iter_unit #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned MUL_LAT   = 2,
   parameter int unsigned EARLY_OUT = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            pcpi_valid,
   input  logic [31:0]     pcpi_insn,
   input  logic [XLEN-1:0] pcpi_rs1,
   input  logic [XLEN-1:0] pcpi_rs2,
   output logic            pcpi_ready,
   output logic            pcpi_wr,
   output logic [XLEN-1:0] pcpi_rd,
   output logic            pcpi_busy
);
   localparam int unsigned CW = $clog2(XLEN + 1);

   typedef enum logic [2:0] {S_IDLE, S_DIV, S_MUL, S_FIX, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [2:0]      r_f3;
   logic [XLEN-1:0] r_rs1, r_rs2, r_abs_b, r_q, r_prem;
   logic            r_neg_a, r_neg_b;
   logic [CW-1:0]   r_cnt;
   logic [2*XLEN-1:0] r_pipe [MUL_LAT];

   function automatic logic [CW-1:0] f_bitlen(input logic [XLEN-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < XLEN; i++)
         if (v[i]) n = CW'(i + 1);
      return n;
   endfunction

   logic [2:0]      w_f3;
   logic            w_accept, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0] w_abs_a, w_abs_b, w_dividend;
   logic            w_dbz, w_ovf, w_small;
   logic [CW-1:0]   w_n;
   logic            w_unused_insn;

   assign w_f3     = pcpi_insn[14:12];
   assign w_accept = pcpi_valid && (r_state == S_IDLE) &&
                     (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
   assign w_sgn_a  = (w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd4) || (w_f3 == 3'd6);
   assign w_sgn_b  = (w_f3 == 3'd1) || (w_f3 == 3'd4) || (w_f3 == 3'd6);
   assign w_neg_a  = w_sgn_a & pcpi_rs1[XLEN-1];
   assign w_neg_b  = w_sgn_b & pcpi_rs2[XLEN-1];
   assign w_abs_a  = w_neg_a ? -pcpi_rs1 : pcpi_rs1;
   assign w_abs_b  = w_neg_b ? -pcpi_rs2 : pcpi_rs2;
   assign w_dbz    = (pcpi_rs2 == '0);
   assign w_ovf    = w_sgn_b && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (pcpi_rs2 == '1);
   assign w_small  = (w_abs_a < w_abs_b);
   assign w_n      = (EARLY_OUT != 0) ? f_bitlen(w_abs_a) : CW'(XLEN);
   // Left-justify the dividend so only its significant bits are iterated.
   assign w_dividend    = w_abs_a << (CW'(XLEN) - w_n);
   assign w_unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   // Multiply operands extended to 2*XLEN; the truncated product is exact
   // for every signed/unsigned combination.
   logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
   assign w_ma   = {{XLEN{r_neg_a}}, r_rs1};
   assign w_mb   = {{XLEN{r_neg_b}}, r_rs2};
   assign w_prod = w_ma * w_mb;

   // Restoring step on an XLEN+1-bit trial remainder.
   logic [XLEN:0]   w_trial;
   logic [XLEN-1:0] w_diff;
   logic            w_fits;
   assign w_trial = {r_prem, r_q[XLEN-1]};
   assign w_fits  = (w_trial >= {1'b0, r_abs_b});
   assign w_diff  = w_trial[XLEN-1:0] - r_abs_b;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      pcpi_busy  = 1'b0;
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_f3[2])                     w_next = S_MUL;
               else if (w_dbz || w_ovf || w_small) w_next = S_DONE;
               else                              w_next = S_DIV;
            end
         end
         S_DIV: begin
            pcpi_busy = 1'b1;
            if (!pcpi_valid)            w_next = S_IDLE;
            else if (r_cnt == CW'(1))   w_next = S_FIX;
         end
         S_MUL: begin
            pcpi_busy = 1'b1;
            if (!pcpi_valid)            w_next = S_IDLE;
            else if (r_cnt == CW'(1))   w_next = S_DONE;
         end
         S_FIX: begin
            pcpi_busy = 1'b1;
            w_next    = pcpi_valid ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            pcpi_ready = 1'b1;
            pcpi_wr    = 1'b1;
            w_next     = S_IDLE;
            case (r_f3)
               3'd0:       pcpi_rd = r_pipe[MUL_LAT-1][XLEN-1:0];
               3'd1, 3'd2,
               3'd3:       pcpi_rd = r_pipe[MUL_LAT-1][2*XLEN-1:XLEN];
               3'd4, 3'd5: pcpi_rd = r_q;
               default:    pcpi_rd = r_prem;
            endcase
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_f3    <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_abs_b <= '0;
         r_neg_a <= 1'b0;
         r_neg_b <= 1'b0;
         r_q     <= '0;
         r_prem  <= '0;
         r_cnt   <= '0;
         for (int unsigned i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_prod;
         for (int unsigned i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
         if (w_accept) begin
            r_f3    <= w_f3;
            r_rs1   <= pcpi_rs1;
            r_rs2   <= pcpi_rs2;
            r_abs_b <= w_abs_b;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_cnt   <= CW'(MUL_LAT);
            if (w_dbz) begin
               r_q    <= '1;
               r_prem <= pcpi_rs1;
            end else if (w_ovf) begin
               r_q    <= pcpi_rs1;
               r_prem <= '0;
            end else if (w_small) begin
               r_q    <= '0;
               r_prem <= pcpi_rs1;
            end else begin
               r_q    <= w_dividend;
               r_prem <= '0;
               if (w_f3[2]) r_cnt <= w_n;
            end
         end else if (r_state == S_DIV) begin
            r_q    <= {r_q[XLEN-2:0], w_fits};
            r_prem <= w_fits ? w_diff : w_trial[XLEN-1:0];
            r_cnt  <= r_cnt - CW'(1);
         end else if (r_state == S_MUL) begin
            r_cnt  <= r_cnt - CW'(1);
         end else if (r_state == S_FIX) begin
            if (r_neg_a ^ r_neg_b) r_q    <= -r_q;
            if (r_neg_a)           r_prem <= -r_prem;
         end
      end
   end
endmodule

// File: tb/tb_m_iter_unit.sv
`timescale 1ns/1ps
module tb_m_iter_unit;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned MUL_LAT   = 2;
   localparam int unsigned EARLY_OUT = 1;
   localparam int unsigned W         = 2*XLEN + 2;

   logic            clk = 1'b0;
   logic            resetn = 1'b1;
   logic            pcpi_valid = 1'b0;
   logic [31:0]     pcpi_insn = '0;
   logic [XLEN-1:0] pcpi_rs1 = '0, pcpi_rs2 = '0;
   logic            pcpi_ready, pcpi_wr, pcpi_busy;
   logic [XLEN-1:0] pcpi_rd;

   logic        v16 = 1'b0;
   logic [31:0] insn16 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        rdy16, wr16, busy16;
   logic [15:0] rd16;

   m_iter_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .EARLY_OUT(EARLY_OUT)) u_dut (
      .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_ready(pcpi_ready),
      .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_busy(pcpi_busy));

   m_iter_unit #(.XLEN(16), .MUL_LAT(4), .EARLY_OUT(0)) u_dut16 (
      .clk(clk), .resetn(resetn), .pcpi_valid(v16), .pcpi_insn(insn16),
      .pcpi_rs1(a16), .pcpi_rs2(b16), .pcpi_ready(rdy16),
      .pcpi_wr(wr16), .pcpi_rd(rd16), .pcpi_busy(busy16));

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;

   // Expected outputs per cycle number; absent entries mean idle (all zero).
   bit              eb [int];
   bit              er [int];
   logic [XLEN-1:0] ed [int];

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_insn(input logic [2:0] f3);
      return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
   endfunction

   // Reference: results from plain signed/unsigned arithmetic, latency from
   // the cycle rules (shortcut=1, multiply=MUL_LAT+1, divide=N+2).
   function automatic void model(input logic [31:0] insn, input logic [XLEN-1:0] a, b,
                                 output bit acc, output logic [XLEN-1:0] rd, output int lat);
      logic [2:0]         f3;
      bit                 sa, sb;
      logic signed [W-1:0] va, vb, p, q, r, ma, mb, t;
      logic [XLEN-1:0]    mn;
      int                 n;
      f3  = insn[14:12];
      acc = (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
      sa  = f3 inside {3'd1, 3'd2, 3'd4, 3'd6};
      sb  = f3 inside {3'd1, 3'd4, 3'd6};
      va  = {{(W-XLEN){sa & a[XLEN-1]}}, a};
      vb  = {{(W-XLEN){sb & b[XLEN-1]}}, b};
      mn  = '0;
      mn[XLEN-1] = 1'b1;
      rd  = '0;
      lat = 0;
      if (!f3[2]) begin
         p   = va * vb;
         rd  = (f3 == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
         lat = MUL_LAT + 1;
      end else if (b == '0) begin
         rd  = f3[1] ? a : '1;
         lat = 1;
      end else if (sb && a == mn && b == '1) begin
         rd  = f3[1] ? '0 : a;
         lat = 1;
      end else begin
         q  = va / vb;
         r  = va % vb;
         rd = f3[1] ? r[XLEN-1:0] : q[XLEN-1:0];
         ma = (va < 0) ? -va : va;
         mb = (vb < 0) ? -vb : vb;
         if (ma < mb) lat = 1;
         else begin
            n = 0;
            t = ma;
            while (t != 0) begin t = t >>> 1; n++; end
            lat = (EARLY_OUT != 0) ? n + 2 : XLEN + 2;
         end
      end
   endfunction

   // Single compare process: checks every cycle against the scheduled expectation.
   initial begin : p_cmp
      bit              xb, xr;
      logic [XLEN-1:0] xd;
      forever begin
         @(negedge clk);
         xb = eb.exists(cyc) ? eb[cyc] : 1'b0;
         xr = er.exists(cyc) ? er[cyc] : 1'b0;
         xd = ed.exists(cyc) ? ed[cyc] : '0;
         nvec++;
         if (pcpi_busy !== xb || pcpi_ready !== xr || pcpi_wr !== xr || pcpi_rd !== xd) begin
            nmis++;
            $display("FAIL cycle %0d outputs: got busy=%b ready=%b wr=%b rd=%h, required busy=%b ready=%b wr=%b rd=%h",
                     cyc, pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd, xb, xr, xr, xd);
         end
      end
   end

   // Called at a negedge; the following posedge is the acceptance edge.
   task automatic run_op(input logic [31:0] insn, input logic [XLEN-1:0] a, b,
                         input int abort_k, input bit scramble, input bit keep_valid,
                         input bit lit, input logic [XLEN-1:0] lit_rd, input int lit_lat);
      bit              acc;
      logic [XLEN-1:0] mrd;
      int              lat, c, end_k;
      model(insn, a, b, acc, mrd, lat);
      if (lit) begin
         nvec++;
         if (mrd !== lit_rd || lat != lit_lat) begin
            nmis++;
            $display("FAIL model-pin insn=%h a=%h b=%h: got rd=%h lat=%0d, required rd=%h lat=%0d",
                     insn, a, b, mrd, lat, lit_rd, lit_lat);
         end
      end
      c          = cyc;
      pcpi_valid = 1'b1;
      pcpi_insn  = insn;
      pcpi_rs1   = a;
      pcpi_rs2   = b;
      if (!acc) begin
         repeat (2) @(negedge clk);
         pcpi_valid = 1'b0;
         @(negedge clk);
         return;
      end
      if (abort_k >= lat) abort_k = 0;
      if (abort_k > 0) begin
         for (int k = 1; k <= abort_k; k++) eb[c+k] = 1'b1;
         end_k = abort_k;
      end else begin
         for (int k = 1; k < lat; k++) eb[c+k] = 1'b1;
         er[c+lat] = 1'b1;
         ed[c+lat] = mrd;
         end_k     = lat;
      end
      for (int k = 1; k <= end_k; k++) begin
         @(negedge clk);
         if (scramble) begin
            pcpi_rs1  = $urandom;
            pcpi_rs2  = $urandom;
            pcpi_insn = $urandom;
         end
      end
      if (abort_k == 0 && keep_valid) @(negedge clk);
      pcpi_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic run16(input logic [2:0] f3, input logic [15:0] a, b,
                        input logic [15:0] xrd, input int xlat);
      int n;
      n      = 0;
      v16    = 1'b1;
      insn16 = {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
      a16    = a;
      b16    = b;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy16 && n < 40);
      nvec++;
      if (!rdy16 || rd16 !== xrd || n != xlat) begin
         nmis++;
         $display("FAIL x16 f3=%0d a=%h b=%h: got ready=%b rd=%h at cycle A+%0d, required rd=%h at A+%0d",
                  f3, a, b, rdy16, rd16, n, xrd, xlat);
      end
      v16 = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [XLEN-1:0] pick();
      logic [XLEN-1:0] v;
      case ($urandom_range(0, 5))
         0: v = $urandom;
         1: v = '0;
         2: v = '1;
         3: begin v = '0; v[XLEN-1] = 1'b1; end
         4: v = XLEN'($urandom_range(0, 20));
         default: v = $urandom >> $urandom_range(0, 31);
      endcase
      return v;
   endfunction

   initial begin : p_drv
      logic [31:0]     insn;
      logic [XLEN-1:0] a, b;
      int              c, ab;
      #1 resetn = 1'b0;
      #1;
      nvec++;
      if (pcpi_busy !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_rd !== '0) begin
         nmis++;
         $display("FAIL reset-state: got busy=%b ready=%b wr=%b rd=%h, required all 0",
                  pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      // Directed cases with hand-computed results and latencies.
      run_op(mk_insn(3'd4), 32'hFFFFFFF9, 32'h2,        0, 0, 0, 1, 32'hFFFFFFFD, 5);
      run_op(mk_insn(3'd6), 32'hFFFFFFF9, 32'h2,        0, 0, 1, 1, 32'hFFFFFFFF, 5);
      run_op(mk_insn(3'd5), 32'h1234,     32'h0,        0, 0, 0, 1, 32'hFFFFFFFF, 1);
      run_op(mk_insn(3'd7), 32'h1234,     32'h0,        0, 0, 0, 1, 32'h00001234, 1);
      run_op(mk_insn(3'd4), 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h80000000, 1);
      run_op(mk_insn(3'd6), 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h00000000, 1);
      run_op(mk_insn(3'd1), 32'h80000000, 32'h80000000, 0, 0, 0, 1, 32'h40000000, 3);
      run_op(mk_insn(3'd2), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'hFFFFFFFF, 3);
      run_op(mk_insn(3'd0), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h00000001, 3);
      run_op(mk_insn(3'd5), 32'd100,      32'd3,        0, 0, 0, 1, 32'd33,        9);
      run_op(mk_insn(3'd4), 32'd5,        32'hFFFFFFF9, 0, 0, 0, 1, 32'd0,         1);
      run_op(mk_insn(3'd6), 32'd5,        32'hFFFFFFF9, 0, 0, 0, 1, 32'd5,         1);
      run_op(mk_insn(3'd5), 32'd100,      32'd3,        5, 0, 0, 0, '0, 0);
      run_op(mk_insn(3'd5), 32'd100,      32'd3,        0, 1, 0, 1, 32'd33,        9);
      insn = mk_insn(3'd0);
      insn[31:25] = 7'b0000000;
      run_op(insn, 32'd7, 32'd9, 0, 0, 0, 0, '0, 0);
      // Reset asserted mid-multiply: outputs must clear before the next edge.
      c = cyc;
      pcpi_valid = 1'b1;
      pcpi_insn  = mk_insn(3'd3);
      pcpi_rs1   = 32'hDEADBEEF;
      pcpi_rs2   = 32'h12345678;
      eb[c+1]    = 1'b1;
      @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      nvec++;
      if (pcpi_busy !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_rd !== '0) begin
         nmis++;
         $display("FAIL mid-mul-reset: got busy=%b ready=%b rd=%h, required all 0",
                  pcpi_busy, pcpi_ready, pcpi_rd);
      end
      pcpi_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      run_op(mk_insn(3'd3), 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 1, 32'hFFFFFFFE, 3);
      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         insn = mk_insn(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 9) == 0) insn[25] = 1'b0;
         a  = pick();
         b  = pick();
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0;
         run_op(insn, a, b, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      // Narrow instance: XLEN=16, MUL_LAT=4, no leading-zero skip.
      run16(3'd5, 16'hFFFF, 16'h0010, 16'h0FFF, 18);
      run16(3'd5, 16'd100,  16'd3,    16'd33,   18);
      run16(3'd7, 16'd100,  16'd3,    16'd1,    18);
      run16(3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5);
      run16(3'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 5);
      run16(3'd4, 16'h8000, 16'hFFFF, 16'h8000, 1);
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/m_iter_unit.md
M_ITER_UNIT -- requirements
Module: m_iter_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width, any even value 8..64.
REQ-002 The block SHALL have parameter MUL_LAT, default 2: multiply pipeline register stages, 1..4.
REQ-003 The block SHALL have parameter EARLY_OUT, default 1: 1 enables leading-zero skip in divide.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset; assertion takes effect without a clock edge, deassertion is synchronous to clk.
REQ-006 pcpi_valid  in  1  request present.
REQ-007 pcpi_insn  in  32  instruction word.
REQ-008 pcpi_rs1, pcpi_rs2  in  XLEN each  operands.
REQ-009 pcpi_ready  out  1  result valid, single-cycle pulse.
REQ-010 pcpi_wr  out  1  write-back enable, equal to pcpi_ready.
REQ-011 pcpi_rd  out  XLEN  result, zero whenever pcpi_ready is low.
REQ-012 pcpi_busy  out  1  operation in progress.

Function
REQ-013 A request SHALL be accepted only in IDLE with pcpi_valid=1, insn[6:0]=7'b0110011 and insn[31:25]=7'b0000001; any other insn leaves the block in IDLE with all outputs 0.
REQ-014 funct3=insn[14:12] SHALL select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-015 At acceptance the block SHALL latch funct3, rs1, rs2, operand signs and absolute values; later changes on pcpi_rs1/rs2/insn have no effect.
REQ-016 States SHALL be IDLE, DIV, MUL, FIX, DONE; the block spends one cycle per state visit, and cycle A is the acceptance cycle.
REQ-017 pcpi_busy SHALL be 1 in DIV, MUL, FIX and 0 in IDLE and DONE.
REQ-018 DONE SHALL assert pcpi_ready=pcpi_wr=1 with pcpi_rd valid for exactly one cycle, then return to IDLE unconditionally; pcpi_valid sampled in DONE is ignored.
REQ-019 Signed operand: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM; all other operands unsigned.
REQ-020 Multiply SHALL form the full 2*XLEN product over MUL_LAT register stages (MUL x MUL_LAT, then DONE), ready in cycle A+MUL_LAT+1; MUL returns the low half, others the high half.
REQ-021 Divide by zero SHALL go directly to DONE (ready in cycle A+1): quotient all-ones, remainder = rs1.
REQ-022 Signed overflow (DIV/REM, rs1=most negative, rs2=all-ones) SHALL go directly to DONE: quotient = rs1, remainder 0.
REQ-023 |rs1|<|rs2| (signedness per REQ-019) SHALL go directly to DONE: quotient 0, remainder = rs1.
REQ-024 Otherwise the block SHALL run restoring division, one quotient bit per DIV cycle, on XLEN+1-bit partial remainder, N iterations: N=XLEN if EARLY_OUT=0, else N=bit length of |rs1|.
REQ-025 Following DIV, FIX SHALL negate the quotient for DIV when the operand signs differ and the remainder for REM when rs1<0; ready in cycle A+N+2.
REQ-026 If pcpi_valid falls in DIV, MUL or FIX, the block SHALL abort: IDLE on the next edge, no ready pulse, no write.
REQ-027 A new request SHALL be accepted no earlier than the IDLE cycle following DONE or abort.

Reset
REQ-028 While resetn=0: state IDLE, counter 0, latched operands 0, and pcpi_ready, pcpi_wr, pcpi_busy, pcpi_rd all 0 immediately, including mid-operation.
REQ-029 The first acceptance after reset release SHALL be possible on the first clock edge with resetn=1.

Verification (XLEN=32, MUL_LAT=2 unless stated)
REQ-030 DIV 0xFFFFFFF9 / 0x00000002 -> rd=0xFFFFFFFD; REM same operands -> rd=0xFFFFFFFF; pulse in cycle A+N+2.
REQ-031 DIVU 0x1234 / 0 -> rd=0xFFFFFFFF in cycle A+1; REMU same -> 0x00001234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-032 MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL same -> 0x00000001; each ready in cycle A+3; MUL_LAT=4 -> A+5.
REQ-033 DIVU 100/3 -> 33 in cycle A+9 with EARLY_OUT=1; in cycle A+34 with EARLY_OUT=0; XLEN=16 DIVU 0xFFFF/0x0010 -> 0x0FFF.
REQ-034 Drop pcpi_valid in 5th DIV cycle -> IDLE next cycle, no ready; resetn=0 mid-MUL -> busy/rd 0 before next edge; a subsequent request completes correctly.
REQ-035 Change pcpi_rs1/rs2 every cycle after acceptance -> result matches latched operands; insn with funct7=0 -> no busy, no ready.
